// File: rtl/tt_sel_seq.sv
// tt_sel_seq: drives a select-counter controller (reset, N inc pulses, enable) to select design address N.
// Define TT_SEL_SEQ_INCR_EN to skip the counter reset when the target is at or above the current address.
module tt_sel_seq #(
    parameter int ADDR_W  = 10,
    parameter int RST_W   = 8,
    parameter int PULSE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid
);
    typedef enum logic [2:0] {IDLE, RESET, SETTLE, INC_HI, INC_LO, ENABLE} state_t;
    localparam logic [7:0] RST_M1 = 8'(RST_W - 1);
    localparam logic [7:0] PW_M1  = 8'(PULSE_W - 1);
    state_t            state;
    logic [7:0]        cnt;
    logic [ADDR_W-1:0] rem;
    logic [ADDR_W-1:0] addr_q;
    logic              ena_q;
    logic              incr;
    logic              last;
    assign req_ready = state == IDLE && !rst;
    assign last      = cnt == 8'd0;
    always_comb begin
`ifdef TT_SEL_SEQ_INCR_EN
        incr = cur_valid && req_addr >= cur_addr;
`else
        incr = 1'b0;
`endif
    end
    // rem counts inc pulses still owed; it only decrements on leaving INC_HI
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            cur_valid      <= 1'b0;
            cur_addr       <= '0;
            cnt            <= '0;
            rem            <= '0;
            addr_q         <= '0;
            ena_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    addr_q         <= req_addr;
                    ena_q          <= req_ena;
                    ctrl_ena       <= 1'b0;
                    ctrl_sel_inc   <= 1'b0;
                    ctrl_sel_rst_n <= incr;
                    state          <= incr ? SETTLE : RESET;
                    cnt            <= incr ? PW_M1 : RST_M1;
                    rem            <= incr ? req_addr - cur_addr : req_addr;
                end
                RESET: if (last) begin
                    state          <= SETTLE;
                    ctrl_sel_rst_n <= 1'b1;
                    cnt            <= PW_M1;
                end else cnt <= cnt - 8'd1;
                SETTLE, INC_LO: if (!last) cnt <= cnt - 8'd1;
                else if (rem == '0) begin
                    state     <= ENABLE;
                    ctrl_ena  <= ena_q;
                    cur_addr  <= addr_q;
                    cur_valid <= 1'b1;
                end else begin
                    state        <= INC_HI;
                    ctrl_sel_inc <= 1'b1;
                    cnt          <= PW_M1;
                end
                INC_HI: if (last) begin
                    state        <= INC_LO;
                    ctrl_sel_inc <= 1'b0;
                    cnt          <= PW_M1;
                    rem          <= rem - 1'b1;
                end else cnt <= cnt - 8'd1;
                ENABLE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/tt_sel_seq.md
TT_SEL_SEQ -- requirements
Module: tt_sel_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, the width of the design address (the mux address plus the user-module index).
REQ-002 SHALL have parameter RST_W, default 8, the number of cycles ctrl_sel_rst_n is held low (range 1..255).
REQ-003 SHALL have parameter PULSE_W, default 4, the number of cycles per inc-high, inc-low and settle phase (range 1..255).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1 bit: a select request is offered.
REQ-007 SHALL have port req_ready, output, 1 bit: the sequencer can accept a request.
REQ-008 SHALL have port req_addr, input, ADDR_W bits: the target design address.
REQ-009 SHALL have port req_ena, input, 1 bit: the ctrl_ena level to apply once the selection completes.
REQ-010 SHALL have port ctrl_sel_rst_n, output, 1 bit: drives the controller's select-counter reset (active-low).
REQ-011 SHALL have port ctrl_sel_inc, output, 1 bit: drives the controller's select-counter increment.
REQ-012 SHALL have port ctrl_ena, output, 1 bit: drives the controller's design enable.
REQ-013 SHALL have port cur_addr, output, ADDR_W bits: the address last fully selected.
REQ-014 SHALL have port cur_valid, output, 1 bit: cur_addr is meaningful.

Function
REQ-015 SHALL register all ctrl_* outputs; no combinational path exists from any input to ctrl_*.
REQ-016 SHALL accept a request only in a cycle where req_valid=1 and req_ready=1; req_addr and req_ena are latched in that cycle, and the following cycle is T0.
REQ-017 SHALL hold req_ready=1 only in state IDLE; req_valid while busy is ignored and has no effect.
REQ-018 SHALL implement states IDLE, RESET, SETTLE, INC_HI, INC_LO and ENABLE.
REQ-019 SHALL drive ctrl_ena=0 from T0 until ENABLE for every accepted request.
REQ-020 SHALL, on the full path, run the following sequence with N = latched address:
- RESET: ctrl_sel_rst_n=0 for RST_W cycles.
- SETTLE: ctrl_sel_rst_n=1 and ctrl_sel_inc=0 for PULSE_W cycles.
- Pulses: N repetitions of INC_HI (ctrl_sel_inc=1 for PULSE_W cycles) then INC_LO (ctrl_sel_inc=0 for PULSE_W cycles).
- ENABLE.
REQ-021 SHALL reach ENABLE at cycle T0+RST_W+PULSE_W*(2N+1) on the full path; when N=0, SETTLE is followed directly by ENABLE.
REQ-022 SHALL, in ENABLE (a single cycle), set ctrl_ena=latched req_ena, cur_addr=N and cur_valid=1, and return to IDLE; req_ready=1 in the next cycle.
REQ-023 SHALL hold ctrl_ena at its new value while IDLE until a new request is accepted.
REQ-024 SHALL use a pulse counter of at least ADDR_W bits so that N = 2^ADDR_W-1 completes without wrap-around.
REQ-025 SHALL never assert ctrl_sel_inc while ctrl_sel_rst_n=0.

Reset
REQ-026 SHALL, while rst=1, force state IDLE, ctrl_sel_rst_n=0, ctrl_sel_inc=0, ctrl_ena=0, cur_valid=0, cur_addr=0 and req_ready=0.
REQ-027 SHALL, when rst is asserted mid-sequence, abandon the sequence and apply the REQ-026 values in the next cycle; after release, req_ready=1 and ctrl_sel_rst_n stays 0 until the next request reaches SETTLE.

Configuration
REQ-028 SHALL, when macro TT_SEL_SEQ_INCR_EN is defined and cur_valid=1 and N>=cur_addr, skip RESET and run the incremental path:
- SETTLE: ctrl_sel_rst_n=1 for PULSE_W cycles.
- Pulses: D = N-cur_addr INC_HI/INC_LO pairs.
- ENABLE at T0+PULSE_W*(2D+1).
REQ-029 SHALL, with TT_SEL_SEQ_INCR_EN defined and N<cur_addr or cur_valid=0, use the full path.
REQ-030 SHALL, without TT_SEL_SEQ_INCR_EN, always use the full path; cur_addr and cur_valid remain as outputs.

Verification
REQ-031 SHALL cover: reset, then request addr=3, ena=1 (defaults) -> ctrl_sel_rst_n=0 for T0..T0+7, three inc pulses 4 high/4 low, ctrl_ena=1 at T0+36, cur_addr=3.
REQ-032 SHALL cover: request addr=0, ena=1 -> no ctrl_sel_inc pulses, ctrl_ena=1 at T0+12.
REQ-033 SHALL cover: req_valid held high during a sequence -> exactly one acceptance, the second request accepted only after req_ready returns.
REQ-034 SHALL cover: rst asserted during the 2nd INC_HI -> next cycle all outputs at REQ-026 values, cur_valid=0.
REQ-035 SHALL cover, with TT_SEL_SEQ_INCR_EN: addr=3 then addr=5 -> second request has 2 pulses with no RESET and ctrl_ena=1 at T0+20; then addr=1 -> full path with RESET.
REQ-036 SHALL cover: addr=1023, PULSE_W=1, RST_W=1 -> 1023 pulses, ctrl_ena at T0+2048, cur_addr=1023.
